alu_mc: RTL and testbench

Parametrised multi-cycle ALU, the next-generation datapath ALU for the processor core. Single-cycle results for add/sub/logic/shift. Iterative shift-add multiply and restoring divide/modulo. All results are registered behind a start/busy/done handshake, so the control unit can stall on long operations instead of closing timing on a combinational multiplier and divider.

---
 rtl/alu_mc.sv | 190 +++++++++++++++++++
 tb/tb_alu_mc.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: WIDTH-bit ALU. Every result is registered behind a start/busy/done handshake.
// Define ALU_MC_MULDIV_EN to build the iterative shift-add multiply and restoring divide/modulo.
module alu_mc #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       selector,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             done,
  output logic             busy,
  output logic             zero,
  output logic             div0,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB = 4'b0001, OP_MUL = 4'b0010, OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD  = 4'b0100, OP_LAND = 4'b0101, OP_LOR = 4'b0110, OP_LNOT = 4'b0111;
  localparam logic [3:0] OP_INV  = 4'b1000, OP_AND = 4'b1001, OP_OR = 4'b1010, OP_XOR = 4'b1011;
  localparam logic [3:0] OP_SHL  = 4'b1100, OP_SHR = 4'b1101;

  typedef struct packed {
    logic [WIDTH-1:0] value;
    logic             illegal;
  } single_t;

  // Mul/div/mod fall into the illegal default; the multi-cycle build intercepts them first.
  function automatic single_t single_op(input logic [3:0] sel, input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y);
    single_t r;
    r.value   = '0;
    r.illegal = 1'b0;
    case (sel)
      OP_ADD:  r.value = x + y;
      OP_SUB:  r.value = x - y;
      OP_LAND: r.value = WIDTH'((x != '0) && (y != '0));
      OP_LOR:  r.value = WIDTH'((x != '0) || (y != '0));
      OP_LNOT: r.value = WIDTH'(x == '0);
      OP_INV:  r.value = ~x;
      OP_AND:  r.value = x & y;
      OP_OR:   r.value = x | y;
      OP_XOR:  r.value = x ^ y;
      OP_SHL:  r.value = {x[WIDTH-2:0], 1'b0};
      OP_SHR:  r.value = {1'b0, x[WIDTH-1:1]};
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  single_t          sc;
  logic             fin;
  logic [WIDTH-1:0] fin_val;
  logic             fin_div0;
  logic             fin_ill;

  assign sc = single_op(selector, a, b);

`ifdef ALU_MC_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t           state, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // sh: multiplicand / dividend-quotient shifter; mp: multiplier / divisor; acc: product / remainder.
  logic [WIDTH-1:0] sh_q, sh_d, mp_q, mp_d, acc_q, acc_d;
  logic             mod_q, mod_d;
  logic [WIDTH-1:0] mul_acc, rem_n, quot_n;
  logic [WIDTH:0]   rem_sh;
  logic             fits, last;

  assign busy    = (state != IDLE);
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign mul_acc = acc_q + (mp_q[0] ? sh_q : '0);
  assign rem_sh  = {acc_q, sh_q[WIDTH-1]};
  assign fits    = (rem_sh >= {1'b0, mp_q});
  assign rem_n   = fits ? WIDTH'(rem_sh - {1'b0, mp_q}) : rem_sh[WIDTH-1:0];
  assign quot_n  = {sh_q[WIDTH-2:0], fits};

  always_comb begin
    // NOTE: every signal driven here is defaulted first so no path can infer a latch.
    state_d  = state;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    mp_d     = mp_q;
    acc_d    = acc_q;
    mod_d    = mod_q;
    fin      = 1'b0;
    fin_val  = '0;
    fin_div0 = 1'b0;
    fin_ill  = 1'b0;
    case (state)
      IDLE: if (start) begin
        cnt_d = '0;
        sh_d  = a;
        mp_d  = b;
        acc_d = '0;
        mod_d = (selector == OP_MOD);
        if (selector == OP_MUL) begin
          state_d = MUL;
        end else if (selector == OP_DIV || selector == OP_MOD) begin
          if (b == '0) begin
            fin      = 1'b1;
            fin_div0 = 1'b1;
            fin_val  = (selector == OP_DIV) ? '1 : a;
          end else begin
            state_d = DIV;
          end
        end else begin
          fin     = 1'b1;
          fin_val = sc.value;
          fin_ill = sc.illegal;
        end
      end
      MUL: begin
        acc_d = mul_acc;
        sh_d  = sh_q << 1;
        mp_d  = mp_q >> 1;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          state_d = IDLE;
          fin     = 1'b1;
          fin_val = mul_acc;
        end
      end
      DIV: begin
        acc_d = rem_n;
        sh_d  = quot_n;
        cnt_d = last ? '0 : cnt_q + CW'(1);
        if (last) begin
          state_d = IDLE;
          fin     = 1'b1;
          fin_val = mod_q ? rem_n : quot_n;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt_q <= '0;
      sh_q  <= '0;
      mp_q  <= '0;
      acc_q <= '0;
      mod_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_d;
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      mp_q  <= mp_d;
      acc_q <= acc_d;
      mod_q <= mod_d;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    fin      = start;
    fin_val  = sc.value;
    fin_div0 = 1'b0;
    fin_ill  = sc.illegal;
  end
`endif

  // Result and flags change only on a done; done itself is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out     <= '0;
      done    <= 1'b0;
      zero    <= 1'b0;
      div0    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      done <= fin;
      if (fin) begin
        out     <= fin_val;
        zero    <= (fin_val == '0);
        div0    <= fin_div0;
        illegal <= fin_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=16); the mul/div tests are built only when
// ALU_MC_MULDIV_EN is defined, otherwise the compiled-out behaviour is checked instead.
module tb_alu_mc;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   selector = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] out;
  logic         done, busy, zero, div0, illegal;

  int vec_count = 0;
  int fail_count = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .selector(selector), .a(a), .b(b),
    .out(out), .done(done), .busy(busy), .zero(zero), .div0(div0), .illegal(illegal)
  );

  // {done, out, zero, div0, illegal}
  function automatic logic [W+3:0] status();
    return {done, out, zero, div0, illegal};
  endfunction

  // Drive one start and return #1 after the accepting edge with start dropped.
  task automatic issue(input logic [3:0] sel, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    start = 1'b1; selector = sel; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count edges after accept until done (bounded); busy_hi includes the accept-cycle sample.
  task automatic wait_done(output int edges, output int busy_hi);
    edges = 0;
    busy_hi = busy ? 1 : 0;
    while (!done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_hi++;
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    #1;
    vec_count++;
    if ({status(), busy} !== '0) begin
      fail_count++; $display("FAIL reset_state: got %h want 0", {status(), busy});
    end
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_single_b2b();
    @(negedge clk);
    start = 1'b1; selector = 4'b0000; a = 16'h7FFF; b = 16'h0001;
    @(posedge clk); #1;
    vec_count++;
    if (status() !== {1'b1, 16'h8000, 3'b000}) begin
      fail_count++; $display("FAIL add_7fff_1: got %h want %h", status(), {1'b1, 16'h8000, 3'b000});
    end
    selector = 4'b0001; a = 16'h0005; b = 16'h0005;
    @(posedge clk); #1;
    start = 1'b0;
    vec_count++;
    if (status() !== {1'b1, 16'h0000, 3'b100}) begin
      fail_count++; $display("FAIL sub_5_5: got %h want %h", status(), {1'b1, 16'h0000, 3'b100});
    end
    @(posedge clk); #1;
    vec_count++;
    if (done !== 1'b0) begin
      fail_count++; $display("FAIL done_single_pulse: got %b want 0", done);
    end
  endtask

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] x, y, exp;
  } vec_t;

  task automatic test_ops_table();
    vec_t v[15];
    v[0]  = '{4'b1000, 16'h00F0, 16'h0000, 16'hFF0F};
    v[1]  = '{4'b1001, 16'hF0F0, 16'h3C3C, 16'h3030};
    v[2]  = '{4'b1010, 16'hF0F0, 16'h0F00, 16'hFFF0};
    v[3]  = '{4'b1011, 16'hFFFF, 16'h00FF, 16'hFF00};
    v[4]  = '{4'b1100, 16'h8001, 16'h0000, 16'h0002};
    v[5]  = '{4'b1101, 16'h8001, 16'h0000, 16'h4000};
    v[6]  = '{4'b0101, 16'h0100, 16'h0002, 16'h0001};
    v[7]  = '{4'b0101, 16'h0000, 16'h0005, 16'h0000};
    v[8]  = '{4'b0110, 16'h0000, 16'h0000, 16'h0000};
    v[9]  = '{4'b0110, 16'h0000, 16'h0008, 16'h0001};
    v[10] = '{4'b0111, 16'h0000, 16'h1234, 16'h0001};
    v[11] = '{4'b0111, 16'h0005, 16'h0000, 16'h0000};
    v[12] = '{4'b0001, 16'h0000, 16'h0001, 16'hFFFF};
    v[13] = '{4'b0000, 16'hFFFF, 16'h0001, 16'h0000};
    v[14] = '{4'b1100, 16'h8000, 16'h0000, 16'h0000};
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      selector = v[i].sel; a = v[i].x; b = v[i].y;
      @(posedge clk); #1;
      vec_count++;
      if (status() !== {1'b1, v[i].exp, (v[i].exp == '0), 2'b00}) begin
        fail_count++;
        $display("FAIL op_table[%0d] sel=%b: got %h want %h", i, v[i].sel, status(),
                 {1'b1, v[i].exp, (v[i].exp == '0), 2'b00});
      end
    end
    start = 1'b0;
  endtask

  task automatic test_illegal();
    issue(4'b1111, 16'h1234, 16'h5678);
    vec_count++;
    if (status() !== {1'b1, 16'h0000, 3'b101}) begin
      fail_count++; $display("FAIL illegal_1111: got %h want %h", status(), {1'b1, 16'h0000, 3'b101});
    end
    issue(4'b1110, 16'hFFFF, 16'hFFFF);
    vec_count++;
    if (status() !== {1'b1, 16'h0000, 3'b101}) begin
      fail_count++; $display("FAIL illegal_1110: got %h want %h", status(), {1'b1, 16'h0000, 3'b101});
    end
    issue(4'b0000, 16'h0002, 16'h0003);
    vec_count++;
    if (status() !== {1'b1, 16'h0005, 3'b000}) begin
      fail_count++; $display("FAIL illegal_cleared: got %h want %h", status(), {1'b1, 16'h0005, 3'b000});
    end
  endtask

`ifdef ALU_MC_MULDIV_EN
  task automatic test_mul();
    int e, bh;
    issue(4'b0010, 16'd300, 16'd250);
    wait_done(e, bh);
    vec_count++;
    if (e !== 16 || bh !== 16) begin
      fail_count++; $display("FAIL mul_timing: got edges=%0d busy=%0d want 16/16", e, bh);
    end
    vec_count++;
    if (status() !== {1'b1, 16'h24F8, 3'b000}) begin
      fail_count++; $display("FAIL mul_300_250: got %h want %h", status(), {1'b1, 16'h24F8, 3'b000});
    end
    @(posedge clk); #1;
    vec_count++;
    if (done !== 1'b0) begin
      fail_count++; $display("FAIL mul_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_div();
    int e, bh;
    issue(4'b0011, 16'h1234, 16'h0000);
    vec_count++;
    if ({status(), busy} !== {1'b1, 16'hFFFF, 3'b010, 1'b0}) begin
      fail_count++; $display("FAIL div_by_zero: got %h want %h", {status(), busy}, {1'b1, 16'hFFFF, 3'b010, 1'b0});
    end
    issue(4'b0100, 16'h1234, 16'h0000);
    vec_count++;
    if (status() !== {1'b1, 16'h1234, 3'b010}) begin
      fail_count++; $display("FAIL mod_by_zero: got %h want %h", status(), {1'b1, 16'h1234, 3'b010});
    end
    issue(4'b0011, 16'd1000, 16'd7);
    wait_done(e, bh);
    vec_count++;
    if (e !== 16 || status() !== {1'b1, 16'h008E, 3'b000}) begin
      fail_count++; $display("FAIL div_1000_7: got edges=%0d %h want 16 %h", e, status(), {1'b1, 16'h008E, 3'b000});
    end
    issue(4'b0100, 16'd1000, 16'd7);
    wait_done(e, bh);
    vec_count++;
    if (e !== 16 || status() !== {1'b1, 16'h0006, 3'b000}) begin
      fail_count++; $display("FAIL mod_1000_7: got edges=%0d %h want 16 %h", e, status(), {1'b1, 16'h0006, 3'b000});
    end
    issue(4'b0100, 16'd14, 16'd7);
    wait_done(e, bh);
    vec_count++;
    if (status() !== {1'b1, 16'h0000, 3'b100}) begin
      fail_count++; $display("FAIL mod_14_7: got %h want %h", status(), {1'b1, 16'h0000, 3'b100});
    end
    issue(4'b0011, 16'hFFFF, 16'h0001);
    wait_done(e, bh);
    vec_count++;
    if (status() !== {1'b1, 16'hFFFF, 3'b000}) begin
      fail_count++; $display("FAIL div_ffff_1: got %h want %h", status(), {1'b1, 16'hFFFF, 3'b000});
    end
  endtask

  task automatic test_busy_ignore();
    int e, bh;
    issue(4'b0010, 16'h00FF, 16'h0002);
    start = 1'b1; selector = 4'b0000; a = 16'h0001; b = 16'h0001;
    wait_done(e, bh);
    start = 1'b0;
    vec_count++;
    if (e !== 16 || status() !== {1'b1, 16'h01FE, 3'b000}) begin
      fail_count++; $display("FAIL busy_ignore: got edges=%0d %h want 16 %h", e, status(), {1'b1, 16'h01FE, 3'b000});
    end
  endtask

  task automatic test_back_to_back();
    int e, bh;
    issue(4'b0010, 16'h0003, 16'h0005);
    wait_done(e, bh);
    vec_count++;
    if (status() !== {1'b1, 16'h000F, 3'b000}) begin
      fail_count++; $display("FAIL mul_3_5: got %h want %h", status(), {1'b1, 16'h000F, 3'b000});
    end
    start = 1'b1; selector = 4'b0000; a = 16'h0004; b = 16'h0004;
    @(posedge clk); #1;
    start = 1'b0;
    vec_count++;
    if ({status(), busy} !== {1'b1, 16'h0008, 3'b000, 1'b0}) begin
      fail_count++; $display("FAIL start_in_done_cycle: got %h want %h", {status(), busy}, {1'b1, 16'h0008, 3'b000, 1'b0});
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    issue(4'b0010, 16'h1234, 16'h0003);
    repeat (8) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    vec_count++;
    if ({status(), busy} !== '0) begin
      fail_count++; $display("FAIL abort_reset: got %h want 0", {status(), busy});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    vec_count++;
    if (dones !== 0) begin
      fail_count++; $display("FAIL abort_no_done: got %0d done/busy cycles want 0", dones);
    end
    issue(4'b0000, 16'h0001, 16'h0001);
    vec_count++;
    if (status() !== {1'b1, 16'h0002, 3'b000}) begin
      fail_count++; $display("FAIL add_after_reset: got %h want %h", status(), {1'b1, 16'h0002, 3'b000});
    end
  endtask
`else
  task automatic test_no_muldiv();
    issue(4'b0010, 16'h0003, 16'h0004);
    vec_count++;
    if ({status(), busy} !== {1'b1, 16'h0000, 3'b101, 1'b0}) begin
      fail_count++; $display("FAIL mul_compiled_out: got %h want %h", {status(), busy}, {1'b1, 16'h0000, 3'b101, 1'b0});
    end
    issue(4'b0011, 16'h0008, 16'h0002);
    vec_count++;
    if ({status(), busy} !== {1'b1, 16'h0000, 3'b101, 1'b0}) begin
      fail_count++; $display("FAIL div_compiled_out: got %h want %h", {status(), busy}, {1'b1, 16'h0000, 3'b101, 1'b0});
    end
    issue(4'b0100, 16'h0008, 16'h0000);
    vec_count++;
    if (status() !== {1'b1, 16'h0000, 3'b101}) begin
      fail_count++; $display("FAIL mod0_compiled_out: got %h want %h", status(), {1'b1, 16'h0000, 3'b101});
    end
    @(posedge clk); #1;
    vec_count++;
    if ({done, busy} !== 2'b00) begin
      fail_count++; $display("FAIL idle_after_compiled_out: got %b want 00", {done, busy});
    end
    issue(4'b0000, 16'h0001, 16'h0001);
    vec_count++;
    if (status() !== {1'b1, 16'h0002, 3'b000}) begin
      fail_count++; $display("FAIL add_after_illegal: got %h want %h", status(), {1'b1, 16'h0002, 3'b000});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_b2b();
    test_ops_table();
    test_illegal();
`ifdef ALU_MC_MULDIV_EN
    test_mul();
    test_div();
    test_busy_ignore();
    test_back_to_back();
    test_abort();
`else
    test_no_muldiv();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
